// File: rtl/hdlc_pkg.sv
// hdlc_pkg: shared HDLC states, line patterns and CRC-16/KERMIT step for the TX and RX channels
package hdlc_pkg;
   typedef enum logic [2:0] {IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT} hdlc_state_e;
   localparam logic [7:0] HDLC_FLAG = 8'h7E;
   localparam logic [7:0] HDLC_ABORT = 8'hFF;
   localparam logic [15:0] CRC_POLY_REFL = 16'h8408;
   localparam logic [15:0] CRC_INIT = 16'h0000;
   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic d);
      return {1'b0, crc[15:1]} ^ ((crc[0] ^ d) ? CRC_POLY_REFL : 16'h0000);
   endfunction
endpackage

// File: rtl/hdlc_fcs_gen.sv
// hdlc_fcs_gen: serial reflected CRC-16 (KERMIT), one payload bit per enabled cycle
module hdlc_fcs_gen
   import hdlc_pkg::*;
(
   input  logic        Clk,
   input  logic        Rst,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);
   logic [15:0] crc_q, crc_d;
   always_comb crc_d = clr ? CRC_INIT : en ? crc_step(crc_q, din) : crc_q;
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) crc_q <= CRC_INIT;
      else crc_q <= crc_d;
   assign crc = crc_q;
endmodule

// File: rtl/hdlc_tx_channel.sv
// hdlc_tx_channel: serial HDLC transmitter - flags, zero insertion, optional FCS, abort
// Tx shows the bit at index bit_q of the current field; each edge picks the next line bit.
module hdlc_tx_channel
   import hdlc_pkg::*;
#(
   parameter int FRAME_MAX = 128
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Tx_Enable,
   input  logic [7:0] Tx_FrameSize,
   input  logic       Tx_FCSen,
   input  logic       Tx_AbortFrame,
   input  logic [7:0] Tx_Data,
   output logic       Tx_RdBuff,
   output logic       Tx,
   output logic       Tx_ValidFrame,
   output logic       Tx_Done,
   output logic       Tx_AbortedTrans
);
   localparam logic [7:0] FMAX = 8'(FRAME_MAX);
   hdlc_state_e state_q, state_d;
   logic [3:0] bit_q, bit_d, nbit, last;
   logic [2:0] ones_q, ones_d;
   logic [7:0] byte_q, byte_d, nxt_q, nxt_d, left_q, left_d, fetch_q, fetch_d;
   logic fcs_en_q, fcs_en_d, tx_q, tx_d, rd_q, rd_d, rd_pend_q;
   logic valid_q, valid_d, done_q, done_d, ab_q, ab_d;
   logic crc_clr, crc_en, crc_din;
   logic [15:0] crc;
   hdlc_fcs_gen u_fcs (
      .Clk(Clk),
      .Rst(Rst),
      .clr(crc_clr),
      .en(crc_en),
      .din(crc_din),
      .crc(crc)
   );
   always_comb begin
      state_d = state_q;
      bit_d = bit_q;
      ones_d = ones_q;
      byte_d = byte_q;
      left_d = left_q;
      fetch_d = fetch_q;
      fcs_en_d = fcs_en_q;
      tx_d = tx_q;
      rd_d = 1'b0;
      ab_d = ab_q;
      crc_clr = 1'b0;
      crc_en = 1'b0;
      crc_din = 1'b0;
      // a stuff bit can delay the byte load past the cycle Tx_Data is valid, so hold it
      nxt_d = rd_pend_q ? Tx_Data : nxt_q;
      nbit = bit_q + 4'd1;
      last = state_q == FCS ? 4'd15 : 4'd7;
      case (state_q)
         IDLE:
            if (Tx_Enable && Tx_FrameSize != 8'd0) begin
               state_d = START_FLAG;
               bit_d = 4'd0;
               tx_d = HDLC_FLAG[0];
               left_d = Tx_FrameSize > FMAX ? FMAX : Tx_FrameSize;
               fetch_d = left_d;
               fcs_en_d = Tx_FCSen;
               ab_d = 1'b0;
               crc_clr = 1'b1;
            end
         START_FLAG, DATA, FCS:
            if (Tx_AbortFrame) begin
               state_d = ABORT;
               bit_d = 4'd0;
               tx_d = HDLC_ABORT[0];
               ab_d = 1'b1;
            end else if (state_q != START_FLAG && ones_q == 3'd5) begin
               tx_d = 1'b0;
               ones_d = 3'd0;
            end else if (bit_q != last) begin
               bit_d = nbit;
               tx_d = state_q == START_FLAG ? HDLC_FLAG[nbit[2:0]] :
                      state_q == DATA ? byte_q[nbit[2:0]] : crc[nbit];
               if (state_q != START_FLAG) ones_d = tx_d ? ones_q + 3'd1 : 3'd0;
               crc_en = state_q == DATA;
               crc_din = tx_d;
               if (state_q != FCS && nbit == 4'd6 && fetch_q != 8'd0) begin
                  rd_d = 1'b1;
                  fetch_d = fetch_q - 8'd1;
               end
            end else if (state_q == FCS || (state_q == DATA && left_q == 8'd0 && !fcs_en_q)) begin
               state_d = END_FLAG;
               bit_d = 4'd0;
               tx_d = HDLC_FLAG[0];
            end else if (state_q == DATA && left_q == 8'd0) begin
               state_d = FCS;
               bit_d = 4'd0;
               tx_d = crc[0];
               ones_d = tx_d ? ones_q + 3'd1 : 3'd0;
            end else begin
               state_d = DATA;
               bit_d = 4'd0;
               byte_d = nxt_d;
               tx_d = nxt_d[0];
               left_d = left_q - 8'd1;
               crc_en = 1'b1;
               crc_din = tx_d;
               ones_d = !tx_d ? 3'd0 : state_q == START_FLAG ? 3'd1 : ones_q + 3'd1;
            end
         END_FLAG, ABORT:
            if (bit_q != 4'd7) begin
               bit_d = nbit;
               tx_d = state_q == END_FLAG ? HDLC_FLAG[nbit[2:0]] : HDLC_ABORT[nbit[2:0]];
            end else begin
               state_d = IDLE;
               tx_d = 1'b1;
            end
         default: state_d = IDLE;
      endcase
      valid_d = state_d inside {START_FLAG, DATA, FCS, END_FLAG};
      done_d = state_d == IDLE;
   end
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) begin
         state_q <= IDLE;
         bit_q <= 4'd0;
         ones_q <= 3'd0;
         byte_q <= 8'd0;
         nxt_q <= 8'd0;
         left_q <= 8'd0;
         fetch_q <= 8'd0;
         fcs_en_q <= 1'b0;
         tx_q <= 1'b1;
         rd_q <= 1'b0;
         rd_pend_q <= 1'b0;
         valid_q <= 1'b0;
         done_q <= 1'b1;
         ab_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q <= bit_d;
         ones_q <= ones_d;
         byte_q <= byte_d;
         nxt_q <= nxt_d;
         left_q <= left_d;
         fetch_q <= fetch_d;
         fcs_en_q <= fcs_en_d;
         tx_q <= tx_d;
         rd_q <= rd_d;
         rd_pend_q <= rd_q;
         valid_q <= valid_d;
         done_q <= done_d;
         ab_q <= ab_d;
      end
   assign Tx = tx_q;
   assign Tx_RdBuff = rd_q;
   assign Tx_ValidFrame = valid_q;
   assign Tx_Done = done_q;
   assign Tx_AbortedTrans = ab_q;
endmodule

// File: tb/tb_hdlc_tx_channel.sv
// tb_hdlc_tx_channel: scoreboard bench - expected line bits queued per frame, popped while Tx_ValidFrame
module tb_hdlc_tx_channel;
   logic Clk = 1'b0, Rst = 1'b0, Tx_Enable = 1'b0, Tx_FCSen = 1'b0, Tx_AbortFrame = 1'b0;
   logic [7:0] Tx_FrameSize = 8'd0;
   logic [7:0] Tx_Data;
   logic Tx_RdBuff, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans;
   int n_chk = 0, n_fail = 0, vcnt = 0, rd_cnt = 0, rd_idx = 0;
   logic [7:0] mem[$];
   logic [7:0] dq[$];
   bit exp_q[$];
   bit line_q[$];
   hdlc_tx_channel #(.FRAME_MAX(128)) dut (
      .Clk(Clk),
      .Rst(Rst),
      .Tx_Enable(Tx_Enable),
      .Tx_FrameSize(Tx_FrameSize),
      .Tx_FCSen(Tx_FCSen),
      .Tx_AbortFrame(Tx_AbortFrame),
      .Tx_Data(Tx_Data),
      .Tx_RdBuff(Tx_RdBuff),
      .Tx(Tx),
      .Tx_ValidFrame(Tx_ValidFrame),
      .Tx_Done(Tx_Done),
      .Tx_AbortedTrans(Tx_AbortedTrans)
   );
   always #5 Clk = ~Clk;
   // buffer model: a pop request presents the next byte for the following cycle
   always @(negedge Clk)
      if (Rst || Tx_Done) rd_idx = 0;
      else if (Tx_RdBuff) begin
         Tx_Data = rd_idx < mem.size() ? mem[rd_idx] : 8'h00;
         rd_idx++;
         rd_cnt++;
      end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic sb_step();
      if (Tx_ValidFrame) begin
         vcnt++;
         line_q.push_back(Tx);
         if (exp_q.size() == 0) chk("sb_extra_bit", 32'd1, 32'd0);
         else chk("sb_bit", Tx, exp_q.pop_front());
      end
   endtask
   task automatic tick();
      @(negedge Clk);
      sb_step();
   endtask
   function automatic void put(input bit b, inout int ones);
      exp_q.push_back(b);
      ones = b ? ones + 1 : 0;
      if (ones == 5) begin
         exp_q.push_back(1'b0);
         ones = 0;
      end
   endfunction
   function automatic logic [15:0] kermit(input logic [7:0] d[$]);
      logic [15:0] c = 16'h0000;
      foreach (d[k]) begin
         c ^= {8'h00, d[k]};
         for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ 16'h8408 : c >> 1;
      end
      return c;
   endfunction
   function automatic void build(input logic [7:0] d[$], input bit fcs);
      logic [7:0] f = 8'h7E;
      logic [15:0] c = kermit(d);
      int ones = 0;
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(f[i]);
      foreach (d[k]) for (int i = 0; i < 8; i++) put(d[k][i], ones);
      if (fcs) for (int i = 0; i < 16; i++) put(c[i], ones);
      for (int i = 0; i < 8; i++) exp_q.push_back(f[i]);
   endfunction
   task automatic start(input logic [7:0] size, input bit fcs, input bit ab);
      @(negedge Clk);
      Tx_FrameSize = size;
      Tx_FCSen = fcs;
      Tx_Enable = 1'b1;
      Tx_AbortFrame = ab;
      tick();
      Tx_Enable = 1'b0;
      Tx_AbortFrame = 1'b0;
   endtask
   task automatic run_frame(input logic [7:0] d[$], input bit fcs, input logic [7:0] size,
                            input int repulse, input bit ab, input string tag);
      int len, cyc, r0;
      build(d, fcs);
      len = exp_q.size();
      mem = d;
      r0 = rd_cnt;
      vcnt = 0;
      start(size, fcs, ab);
      chk({tag, "_done_fall"}, Tx_Done, 0);
      chk({tag, "_aborted_clr"}, Tx_AbortedTrans, 0);
      cyc = 1;
      while (!Tx_Done && cyc < 3000) begin
         Tx_Enable = cyc == repulse;
         if (cyc == repulse) Tx_FrameSize = 8'd7;
         tick();
         cyc++;
      end
      Tx_Enable = 1'b0;
      chk({tag, "_done_cycle"}, cyc, len + 1);
      chk({tag, "_rd_pulses"}, rd_cnt - r0, d.size());
      chk({tag, "_valid_cycles"}, vcnt, len);
      chk({tag, "_sb_left"}, exp_q.size(), 0);
   endtask
   initial begin
      int cyc, r0, l0, ones;
      bit bad;
      logic [8:0] v;
      logic [7:0] lo, hi;
      bit pl[$];
      #1 Rst = 1'b1;
      #2;
      chk("rst_tx", Tx, 1);
      chk("rst_rd", Tx_RdBuff, 0);
      chk("rst_valid", Tx_ValidFrame, 0);
      chk("rst_done", Tx_Done, 1);
      chk("rst_aborted", Tx_AbortedTrans, 0);
      @(negedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      dq = {8'h01, 8'h02};
      run_frame(dq, 1'b0, 8'd2, 0, 1'b0, "two_bytes");
      l0 = line_q.size();
      dq = {8'hFF};
      run_frame(dq, 1'b0, 8'd1, 0, 1'b0, "ff_byte");
      v = '0;
      if (line_q.size() >= l0 + 17) for (int i = 0; i < 9; i++) v = {v[7:0], line_q[l0 + 8 + i]};
      chk("ff_field", v, 9'b111110111);
      l0 = line_q.size();
      dq = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      run_frame(dq, 1'b1, 8'd9, 0, 1'b0, "check_str");
      pl.delete();
      ones = 0;
      for (int i = l0 + 8; i < line_q.size() - 8; i++)
         if (ones == 5) ones = 0;
         else begin
            pl.push_back(line_q[i]);
            ones = line_q[i] ? ones + 1 : 0;
         end
      chk("check_str_payload_bits", pl.size(), 88);
      lo = '0;
      hi = '0;
      if (pl.size() >= 88) for (int i = 0; i < 8; i++) begin
         lo[i] = pl[72 + i];
         hi[i] = pl[80 + i];
      end
      chk("check_str_fcs_lo", lo, 8'h89);
      chk("check_str_fcs_hi", hi, 8'h21);
      dq = {8'h01, 8'h02, 8'h03};
      build(dq, 1'b1);
      while (exp_q.size() > 19) void'(exp_q.pop_back());
      mem = dq;
      r0 = rd_cnt;
      vcnt = 0;
      start(8'd3, 1'b1, 1'b0);
      cyc = 1;
      while (cyc < 19) begin
         tick();
         cyc++;
      end
      Tx_AbortFrame = 1'b1;
      tick();
      cyc++;
      Tx_AbortFrame = 1'b0;
      chk("abort_tx", Tx, 1);
      chk("abort_valid", Tx_ValidFrame, 0);
      chk("abort_flag_set", Tx_AbortedTrans, 1);
      bad = 1'b0;
      while (!Tx_Done && cyc < 100) begin
         bad |= !Tx || Tx_ValidFrame;
         tick();
         cyc++;
      end
      chk("abort_ones", bad, 0);
      chk("abort_done_cycle", cyc, 28);
      chk("abort_rd_pulses", rd_cnt - r0, 2);
      chk("abort_valid_cycles", vcnt, 19);
      chk("abort_sb_left", exp_q.size(), 0);
      chk("abort_flag_sticky", Tx_AbortedTrans, 1);
      dq = {8'h11, 8'h22};
      run_frame(dq, 1'b0, 8'd2, 0, 1'b0, "post_abort");
      dq = {8'h55, 8'hAA, 8'h0F};
      run_frame(dq, 1'b1, 8'd3, 12, 1'b0, "repulse");
      dq = {8'h7E};
      run_frame(dq, 1'b0, 8'd1, 0, 1'b1, "en_with_abort");
      r0 = rd_cnt;
      @(negedge Clk);
      Tx_FrameSize = 8'd0;
      Tx_Enable = 1'b1;
      tick();
      Tx_Enable = 1'b0;
      Tx_AbortFrame = 1'b1;
      tick();
      Tx_AbortFrame = 1'b0;
      bad = 1'b0;
      repeat (20) begin
         tick();
         bad |= !Tx || !Tx_Done || Tx_ValidFrame;
      end
      chk("size0_idle", bad, 0);
      chk("size0_rd_pulses", rd_cnt - r0, 0);
      chk("idle_abort_ignored", Tx_AbortedTrans, 0);
      dq = {8'h3C, 8'h5A};
      build(dq, 1'b0);
      while (exp_q.size() > 12) void'(exp_q.pop_back());
      mem = dq;
      start(8'd2, 1'b0, 1'b0);
      cyc = 1;
      while (cyc < 12) begin
         tick();
         cyc++;
      end
      #2 Rst = 1'b1;
      #1;
      chk("midrst_tx", Tx, 1);
      chk("midrst_done", Tx_Done, 1);
      chk("midrst_valid", Tx_ValidFrame, 0);
      chk("midrst_rd", Tx_RdBuff, 0);
      chk("midrst_sb_left", exp_q.size(), 0);
      @(negedge Clk);
      Rst = 1'b0;
      dq = {8'hA5};
      run_frame(dq, 1'b1, 8'd1, 0, 1'b0, "post_rst");
      dq.delete();
      for (int i = 0; i < 128; i++) dq.push_back(8'($urandom));
      run_frame(dq, 1'b1, 8'd200, 0, 1'b0, "clamp");
      for (int f = 0; f < 4; f++) begin
         dq.delete();
         for (int i = 0; i < int'($urandom_range(1, 6)); i++) dq.push_back(8'($urandom));
         run_frame(dq, 1'($urandom), 8'(dq.size()), 0, 1'b0, "random");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
